// File: rtl/satrnd_pkg.sv
// Shared types and width helpers for the satrnd_pipe saturate/round pipeline.
package satrnd_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2
    } rnd_mode_e;

    function automatic int calc_ow(input int msb_out, input int lsb_out);
        return msb_out - lsb_out + 1;
    endfunction

endpackage

// File: rtl/satrnd_lane.sv
// One lane of the saturate/round datapath, purely combinational.
// The round-sum half feeds stage 1; the overflow/saturate half is driven from stage 1 registers.
module satrnd_lane
    import satrnd_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MSB_OUT = 6,
    parameter int LSB_OUT = 2,
    localparam int OW     = calc_ow(MSB_OUT, LSB_OUT),
    localparam int SW     = WIDTH - LSB_OUT + 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic             tc,
    input  rnd_mode_e        rnd_mode,
    output logic [SW-1:0]    sum,
    input  logic [SW-1:0]    s_q,
    input  logic             tc_q,
    input  logic             sat_q,
    output logic [OW-1:0]    res,
    output logic             ov
);

    logic          r;
    logic [SW-OW:0] top_bits;
    logic [OW-1:0] sat_pos;
    logic [OW-1:0] sat_neg;

    generate
        if (LSB_OUT == 0) begin : g_no_rnd
            assign r = 1'b0;
        end else begin : g_rnd
            logic half;
            logic odd;
            logic below;
            assign half = din[LSB_OUT-1];
            assign odd  = din[LSB_OUT];
            if (LSB_OUT == 1) begin : g_l1
                assign below = 1'b0;
            end else begin : g_ln
                assign below = |din[LSB_OUT-2:0];
            end
            always_comb begin
                case (rnd_mode)
                    RND_HALF_UP:   r = half;
                    RND_HALF_EVEN: r = half & (below | odd);
                    default:       r = 1'b0;
                endcase
            end
        end
    endgenerate

    // One guard bit above the kept field so the +1 of rounding never wraps.
    assign sum = {tc & din[WIDTH-1], din[WIDTH-1:LSB_OUT]} + {{(SW-1){1'b0}}, r};

    assign top_bits = s_q[SW-1:OW-1];

    always_comb begin
        sat_pos          = '1;
        sat_pos[OW-1]    = 1'b0;
        sat_neg          = '0;
        sat_neg[OW-1]    = 1'b1;
        if (tc_q) begin
            ov = !((&top_bits) | ~(|top_bits));
        end else begin
            ov = |s_q[SW-1:OW];
        end
        res = s_q[OW-1:0];
        if (ov && sat_q) begin
            if (!tc_q) begin
                res = '1;
            end else if (s_q[SW-1]) begin
                res = sat_neg;
            end else begin
                res = sat_pos;
            end
        end
    end

endmodule

// File: rtl/satrnd_pipe.sv
// Two-stage, multi-lane saturate/round pipeline with valid/ready back-pressure.
// Macro SATRND_OVCNT_EN adds per-lane saturating overflow counters and the ov_cnt port.
module satrnd_pipe
    import satrnd_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MSB_OUT = 6,
    parameter int LSB_OUT = 2,
    parameter int LANES   = 4,
    parameter int CNT_W   = 16,
    localparam int OW     = calc_ow(MSB_OUT, LSB_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] din,
    input  logic                   tc,
    input  logic                   sat,
    input  logic [1:0]             rnd_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OW-1:0]    dout,
    output logic [LANES-1:0]       ov,
    input  logic                   clr_sticky,
    output logic [LANES-1:0]       ov_sticky
`ifdef SATRND_OVCNT_EN
    ,
    output logic [LANES*CNT_W-1:0] ov_cnt
`endif
);

    localparam int SW = WIDTH - LSB_OUT + 1;

    generate
        if (MSB_OUT > WIDTH - 1 || LSB_OUT < 0 || LSB_OUT > MSB_OUT || LANES < 1 || CNT_W < 1)
        begin : g_bad_param
            $error("satrnd_pipe: illegal parameter combination");
        end
    endgenerate

    logic              s1_valid;
    logic              s2_valid;
    logic              s1_tc;
    logic              s1_sat;
    logic              s1_adv;
    logic              s2_adv;
    logic [SW-1:0]     s1_sum [LANES];
    logic [SW-1:0]     sum_c  [LANES];
    logic [OW-1:0]     res_c  [LANES];
    logic [LANES-1:0]  ov_c;
    logic [LANES-1:0]  ov_set;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = s2_adv || !s1_valid;
    assign in_ready  = !s1_valid || s1_adv;
    assign out_valid = s2_valid;
    assign ov_set    = {LANES{s2_valid & out_ready}} & ov;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            satrnd_lane #(
                .WIDTH   (WIDTH),
                .MSB_OUT (MSB_OUT),
                .LSB_OUT (LSB_OUT)
            ) u_lane (
                .din      (din[i*WIDTH +: WIDTH]),
                .tc       (tc),
                .rnd_mode (rnd_mode_e'(rnd_mode)),
                .sum      (sum_c[i]),
                .s_q      (s1_sum[i]),
                .tc_q     (s1_tc),
                .sat_q    (s1_sat),
                .res      (res_c[i]),
                .ov       (ov_c[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_tc    <= 1'b0;
            s1_sat   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_sum[i] <= '0;
            end
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_tc  <= tc;
                s1_sat <= sat;
                for (int i = 0; i < LANES; i++) begin
                    s1_sum[i] <= sum_c[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            dout     <= '0;
            ov       <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                ov <= ov_c;
                for (int i = 0; i < LANES; i++) begin
                    dout[i*OW +: OW] <= res_c[i];
                end
            end
        end
    end

    // A flag set on the same cycle as a clear takes priority so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_sticky <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (ov_set[i]) begin
                    ov_sticky[i] <= 1'b1;
                end else if (clr_sticky) begin
                    ov_sticky[i] <= 1'b0;
                end
            end
        end
    end

`ifdef SATRND_OVCNT_EN
    logic [CNT_W-1:0] cnt_q [LANES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (clr_sticky) begin
                    cnt_q[i] <= ov_set[i] ? CNT_W'(1) : '0;
                end else if (ov_set[i] && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        ov_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            ov_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_satrnd_pipe.sv
// Self-checking bench for satrnd_pipe: directed cases, random traffic against an arithmetic model,
// back-pressure, sticky/counter behaviour and mid-stream reset.
module tb_satrnd_pipe;

    localparam int W     = 8;
    localparam int MSB   = 6;
    localparam int LSB   = 2;
    localparam int LANES = 4;
    localparam int CNT_W = 2;
    localparam int OW    = MSB - LSB + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  tc = 1'b0;
    logic                  sat = 1'b0;
    logic [1:0]            rnd_mode = 2'd0;
    logic                  out_ready = 1'b0;
    logic                  clr_sticky = 1'b0;
    logic [LANES*W-1:0]    din = '0;
    logic                  in_ready;
    logic                  out_valid;
    logic [LANES*OW-1:0]   dout;
    logic [LANES-1:0]      ov;
    logic [LANES-1:0]      ov_sticky;
`ifdef SATRND_OVCNT_EN
    logic [LANES*CNT_W-1:0] ov_cnt;
`endif

    always #5 clk = ~clk;

    satrnd_pipe #(
        .WIDTH   (W),
        .MSB_OUT (MSB),
        .LSB_OUT (LSB),
        .LANES   (LANES),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .tc         (tc),
        .sat        (sat),
        .rnd_mode   (rnd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .ov         (ov),
        .clr_sticky (clr_sticky),
        .ov_sticky  (ov_sticky)
`ifdef SATRND_OVCNT_EN
        ,
        .ov_cnt     (ov_cnt)
`endif
    );

    typedef struct packed {
        logic [LANES*OW-1:0] d;
        logic [LANES-1:0]    v;
    } beat_t;

    beat_t            exp_q[$];
    beat_t            m_b;
    logic [LANES-1:0] m_set;
    logic [LANES-1:0] m_sticky = '0;
    int               m_cnt [LANES];
    int               n_acc = 0;
    int               n_chk = 0;
    int               n_fail = 0;

    // Reference: interpret the word as an integer, divide by 2^LSB with the chosen rounding, then range-check.
    function automatic beat_t model(input logic [LANES*W-1:0] d, input logic t, input logic s,
                                    input logic [1:0] rm);
        beat_t      b;
        logic [W-1:0] x;
        int         v, q, rem, r, sv, res, half;
        logic       o;
        b = '0;
        half = (LSB > 0) ? (1 << (LSB - 1)) : 0;
        for (int i = 0; i < LANES; i++) begin
            x   = d[i*W +: W];
            v   = t ? int'($signed(x)) : int'(x);
            q   = v >>> LSB;
            rem = v - q * (1 << LSB);
            r   = 0;
            if (LSB > 0) begin
                if (rm == 2'd1 && rem >= half) r = 1;
                if (rm == 2'd2 && (rem > half || (rem == half && (q % 2) != 0))) r = 1;
            end
            sv = q + r;
            if (t) o = (sv < -(1 << (OW - 1))) || (sv > (1 << (OW - 1)) - 1);
            else   o = sv > (1 << OW) - 1;
            if (o && s) res = t ? (sv < 0 ? (1 << (OW - 1)) : (1 << (OW - 1)) - 1) : (1 << OW) - 1;
            else        res = sv & ((1 << OW) - 1);
            b.d[i*OW +: OW] = res[OW-1:0];
            b.v[i] = o;
        end
        return b;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_sticky = '0;
            for (int i = 0; i < LANES; i++) m_cnt[i] = 0;
        end else begin
            m_set = '0;
            if (out_valid && out_ready && exp_q.size() > 0) begin
                m_b   = exp_q.pop_front();
                m_set = m_b.v;
            end
            for (int i = 0; i < LANES; i++) begin
                if (m_set[i]) m_sticky[i] = 1'b1;
                else if (clr_sticky) m_sticky[i] = 1'b0;
                if (clr_sticky) m_cnt[i] = m_set[i] ? 1 : 0;
                else if (m_set[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(din, tc, sat, rnd_mode));
                n_acc = n_acc + 1;
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_chk++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
        n_chk++; if (ov !== '0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", ov); end
        n_chk++; if (ov_sticky !== '0) begin n_fail++; $display("FAIL reset_sticky: got %b want 0", ov_sticky); end
`ifdef SATRND_OVCNT_EN
        n_chk++; if (ov_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", ov_cnt); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int vd [7] = '{'h3E, 'h3E, 'h9C, 'h9C, 'h0A, 'h0E, 'h0A};
        int vt [7] = '{1, 1, 0, 0, 1, 1, 1};
        int vs [7] = '{1, 0, 1, 0, 1, 1, 1};
        int vr [7] = '{1, 1, 0, 0, 2, 2, 1};
        int ed [7] = '{'h0F, 'h10, 'h1F, 'h07, 'h02, 'h04, 'h03};
        int eo [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [W-1:0]  x;
        logic [OW-1:0] e;
        int lat;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            x         = W'(vd[k]);
            e         = OW'(ed[k]);
            din       = {LANES{x}};
            tc        = vt[k][0];
            sat       = vs[k][0];
            rnd_mode  = 2'(vr[k]);
            in_valid  = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_chk++;
            if (lat != 2) begin n_fail++; $display("FAIL dir_latency[%0d]: got %0d want 2", k, lat); end
            n_chk++;
            if (dout !== {LANES{e}}) begin
                n_fail++; $display("FAIL dir_dout[%0d]: got %h want %h", k, dout, {LANES{e}});
            end
            n_chk++;
            if (ov !== {LANES{eo[k][0]}}) begin
                n_fail++; $display("FAIL dir_ov[%0d]: got %b want %b", k, ov, {LANES{eo[k][0]}});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int start = n_acc;
        int cyc = 0;
        bit sending = 1'b1;
        while ((sending || exp_q.size() > 0 || out_valid) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            n_chk++;
            if (ov_sticky !== m_sticky) begin
                n_fail++; $display("FAIL rand_sticky: got %b want %b", ov_sticky, m_sticky);
            end
`ifdef SATRND_OVCNT_EN
            for (int i = 0; i < LANES; i++) begin
                n_chk++;
                if (ov_cnt[i*CNT_W +: CNT_W] !== CNT_W'(m_cnt[i])) begin
                    n_fail++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, ov_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
                end
            end
`endif
            sending    = (n_acc - start) < 300;
            in_valid   = sending && ($urandom_range(0, 3) != 0);
            for (int i = 0; i < LANES; i++) din[i*W +: W] = W'($urandom);
            tc         = 1'($urandom_range(0, 1));
            sat        = 1'($urandom_range(0, 1));
            rnd_mode   = 2'($urandom_range(0, 3));
            clr_sticky = ($urandom_range(0, 15) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious: got beat %h want none", dout);
                end else if (dout !== exp_q[0].d || ov !== exp_q[0].v) begin
                    n_fail++; $display("FAIL rand_beat: got %h/%b want %h/%b", dout, ov, exp_q[0].d, exp_q[0].v);
                end
            end
        end
        n_chk++;
        if (cyc >= 5000) begin n_fail++; $display("FAIL rand_timeout: got %0d cycles want < 5000", cyc); end
        in_valid   = 1'b0;
        clr_sticky = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic test_backpressure();
        int acc0;
        int seq = 1;
        int cyc = 0;
        bit have_hold = 1'b0;
        logic [LANES*OW-1:0] hold = '0;
        @(negedge clk);
        acc0      = n_acc;
        out_ready = 1'b0;
        tc = 1'b1; sat = 1'b0; rnd_mode = 2'd1;
        din       = {LANES{W'(seq * 8)}};
        in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            n_chk++;
            if (in_ready !== ((n_acc - acc0) < 2)) begin
                n_fail++; $display("FAIL bp_in_ready: got %b want %b", in_ready, (n_acc - acc0) < 2);
            end
            if (out_valid) begin
                if (!have_hold) begin
                    hold = dout; have_hold = 1'b1;
                end else begin
                    n_chk++;
                    if (dout !== hold) begin n_fail++; $display("FAIL bp_stable: got %h want %h", dout, hold); end
                end
            end
            seq++;
            din = {LANES{W'(seq * 8)}};
        end
        n_chk++;
        if (n_acc - acc0 != 2) begin n_fail++; $display("FAIL bp_held: got %0d want 2", n_acc - acc0); end
        out_ready = 1'b1;
        repeat (4) begin
            n_chk++;
            if (!out_valid || exp_q.size() == 0 || dout !== exp_q[0].d || ov !== exp_q[0].v) begin
                n_fail++; $display("FAIL bp_order: got %b/%h want beat %h", out_valid, dout,
                                   exp_q.size() > 0 ? exp_q[0].d : '0);
            end
            @(negedge clk);
            seq++;
            din = {LANES{W'(seq * 8)}};
        end
        in_valid = 1'b0;
        while (exp_q.size() > 0 && cyc < 20) begin
            if (out_valid) begin
                n_chk++;
                if (dout !== exp_q[0].d || ov !== exp_q[0].v) begin
                    n_fail++; $display("FAIL bp_drain: got %h want %h", dout, exp_q[0].d);
                end
            end
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (exp_q.size() != 0 || out_valid) begin
            n_fail++; $display("FAIL bp_empty: got %0d queued/%b want 0/0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_sticky();
        int lat = 0;
        @(negedge clk);
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        n_chk++;
        if (ov_sticky !== '0) begin n_fail++; $display("FAIL st_clear: got %b want 0", ov_sticky); end
        out_ready = 1'b1;
        tc = 1'b1; sat = 1'b1; rnd_mode = 2'd1;
        din = '0;
        din[W-1:0] = 8'h3E;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_chk++;
        if (ov_sticky !== 4'b0001) begin n_fail++; $display("FAIL st_set: got %b want 0001", ov_sticky); end
`ifdef SATRND_OVCNT_EN
        n_chk++;
        if (ov_cnt[CNT_W-1:0] !== 2'd3) begin n_fail++; $display("FAIL cnt_sat: got %0d want 3", ov_cnt[CNT_W-1:0]); end
        n_chk++;
        if (ov_cnt[2*CNT_W-1:CNT_W] !== 2'd0) begin n_fail++; $display("FAIL cnt_lane1: got %0d want 0", ov_cnt[2*CNT_W-1:CNT_W]); end
`endif
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_chk++;
        if (!out_valid) begin n_fail++; $display("FAIL st_wait: got out_valid 0 want 1"); end
        clr_sticky = 1'b1;
        @(negedge clk);
        clr_sticky = 1'b0;
        n_chk++;
        if (ov_sticky !== 4'b0001) begin n_fail++; $display("FAIL st_coincide: got %b want 0001", ov_sticky); end
`ifdef SATRND_OVCNT_EN
        n_chk++;
        if (ov_cnt !== {{(LANES-1)*CNT_W{1'b0}}, 2'd1}) begin
            n_fail++; $display("FAIL cnt_coincide: got %h want 1", ov_cnt);
        end
`endif
        n_chk++;
        if (ov_sticky !== m_sticky) begin n_fail++; $display("FAIL st_model: got %b want %b", ov_sticky, m_sticky); end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < LANES; i++) din[i*W +: W] = W'($urandom);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        n_chk++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rm_full: got %b/%b want 1/0", out_valid, in_ready);
        end
        rst = 1'b1;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_in_ready: got %b want 1", in_ready); end
        n_chk++; if (ov_sticky !== '0) begin n_fail++; $display("FAIL rm_sticky: got %b want 0", ov_sticky); end
        n_chk++; if (dout !== '0) begin n_fail++; $display("FAIL rm_dout: got %h want 0", dout); end
`ifdef SATRND_OVCNT_EN
        n_chk++; if (ov_cnt !== '0) begin n_fail++; $display("FAIL rm_cnt: got %h want 0", ov_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_no_output: got %b want 0", out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_sticky();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/satrnd_pipe.md
# satrnd_pipe

Pipelined, multi-lane successor to the combinational saturate/round cell. Each of `LANES` signed or unsigned words is reduced to bit field `[MSB_OUT:LSB_OUT]` with selectable rounding (truncate, round-half-up, round-half-even), optional saturation, per-lane overflow flags, sticky flags and overflow event counters. It sits between the datapath accumulators and narrower downstream consumers, and uses a valid/ready handshake with full back-pressure.

## Interface
- `WIDTH`, default 8: input word width per lane.
- `MSB_OUT`, default 6: top kept bit. `MSB_OUT <= WIDTH-1`.
- `LSB_OUT`, default 2: bottom kept bit. `0 <= LSB_OUT <= MSB_OUT`.
- `LANES`, default 4: number of parallel lanes.
- `CNT_W`, default 16: overflow counter width.
- `OW` is derived, not overridable: `MSB_OUT-LSB_OUT+1`.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: input beat valid.
- `in_ready`, out, 1: block can accept a beat.
- `din`, in, LANES*WIDTH: lane i is `din[i*WIDTH +: WIDTH]`.
- `tc`, in, 1: 1 selects two's complement, 0 selects unsigned.
- `sat`, in, 1: 1 selects saturate on overflow, 0 selects wrap.
- `rnd_mode`, in, 2: 0 truncate, 1 half-up, 2 half-even, 3 treated as truncate.
- `out_valid`, out, 1: output beat valid.
- `out_ready`, in, 1: consumer accepts the beat.
- `dout`, out, LANES*OW: result lanes.
- `ov`, out, LANES: per-lane overflow flag for the current output beat.
- `clr_sticky`, in, 1: synchronous clear of sticky flags and counters.
- `ov_sticky`, out, LANES: per-lane sticky overflow flag.
- `ov_cnt`, out, LANES*CNT_W: per-lane counters. This port exists only under the configuration macro.

## Operation
- `tc`, `sat` and `rnd_mode` are captured with each accepted beat and travel with it. Changing them mid-stream never affects beats already accepted.
- Round increment `r`:
  - Always 0 when `LSB_OUT == 0`.
  - Half-up: `r = din[LSB_OUT-1]`.
  - Half-even: `r = din[LSB_OUT-1] & (|din[LSB_OUT-2:0] | din[LSB_OUT])`. The low-bits OR term is 0 when `LSB_OUT == 1`.
- Rounded value: `s = din[WIDTH-1:LSB_OUT] + r`.
  - The sum is computed at `WIDTH-LSB_OUT+1` bits.
  - The upper operand is sign-extended when `tc=1` and zero-extended when `tc=0`.
- Overflow:
  - `tc=1`: `s` lies outside `[-2^(OW-1), 2^(OW-1)-1]`.
  - `tc=0`: `s > 2^OW-1`.
- Result:
  - On overflow with `sat=1`: `tc=1` gives `0111..1` for positive `s` or `1000..0` for negative `s`; `tc=0` gives all ones.
  - Otherwise: `dout = s[OW-1:0]`, i.e. wraps.
- Sticky flag, lane i:
  - Set on an output handshake (`out_valid & out_ready`) with `ov[i]=1`.
  - Cleared by `clr_sticky`.
  - If set and clear occur in the same cycle, set wins.
- Counter, lane i:
  - Increments on the same set condition and saturates at `2^CNT_W-1`.
  - `clr_sticky` zeroes it; if clear coincides with an increment, the counter is loaded with 1.

## Timing
- Two register stages.
  - S1 registers the rounded sum plus the captured controls.
  - S2 registers `dout`/`ov` after overflow detection and saturation.
- Latency is 2 cycles from input handshake to `out_valid` when unstalled. Throughput is 1 beat per cycle.
- Back-pressure:
  - S2 advances when `!s2_valid | out_ready`.
  - S1 advances when S2 advances or S1 is empty.
  - `in_ready = !s1_valid | s1_advance`.
  - There is no combinational path from `in_valid` to `out_valid`. `in_ready` depends combinationally on `out_ready`.
- `out_valid` never drops without a handshake. `dout`/`ov` stay stable while `out_valid & !out_ready`.
- Reset values: `in_ready=1`, `out_valid=0`, `dout=0`, `ov=0`, `ov_sticky=0`, `ov_cnt=0`, internal stage valids 0.
- Reset asserted mid-stream discards in-flight beats immediately, with no partial output.

## Configuration
- Macro `SATRND_OVCNT_EN`.
- Defined: the `ov_cnt` port and its counters are built.
- Undefined: the port is absent and no counter flops exist. `ov_sticky` and all other behaviour are unchanged.

## Structure
- Package `satrnd_pkg` contains:
  - `rnd_mode_e` enum (`RND_TRUNC`, `RND_HALF_UP`, `RND_HALF_EVEN`).
  - Width-derivation function for `OW`.
- Sub-module `satrnd_lane` is purely combinational and handles one lane: round-sum, then overflow, then saturate/wrap.
  - It is instantiated `LANES` times, split across the S1/S2 boundary (round-sum output feeds S1; overflow/saturate output feeds S2).
- Handshake, stage registers, sticky flags and counters live in the top level.

## Test plan
- Defaults, `tc=1`, `sat=1`, `rnd_mode=1`, `din` lane=`0x3E` -> `dout=0x0F`, `ov=1`. Repeat with `sat=0` -> `dout=0x10`, `ov=1`.
- `tc=0`, `rnd_mode=0`, `din=0x9C`: with `sat=1` -> `dout=0x1F`, `ov=1`; with `sat=0` -> `dout=0x07`.
- `tc=1`, `rnd_mode=2`: `din=0x0A` -> `dout=0x02`; `din=0x0E` -> `dout=0x04`; `din=0x0A` with `rnd_mode=1` -> `dout=0x03`; all with `ov=0`.
- Continuous input with `out_ready` held low for 5 cycles:
  - `in_ready` falls after 2 beats are held.
  - No beat is lost or duplicated and order is preserved.
  - `dout` is stable while stalled.
- `CNT_W=2`, macro defined: 5 overflow handshakes on lane 0 -> `ov_cnt` lane0=3 (saturated), `ov_sticky[0]=1`. Then `clr_sticky` coincident with a 6th overflow -> sticky=1, counter=1.
- Assert `rst` with both stages valid and `out_ready=0` -> `out_valid=0` in the same cycle; stickies and counters are 0; `in_ready=1`.
